// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control unit: a registered sequencer that drives the datapath
// multiplexers and write enables from the current state, Instr, ALU flags and MemReady.
module multicycle_controller #(
    parameter bit FULL_BRANCH = 1'b1,
    parameter bit EXT_ALU     = 1'b1,
    parameter bit TRAP_HALT   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        Neg,
    input  logic        Carry,
    input  logic        Ovf,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        Illegal
);
    typedef enum logic [3:0] {
        ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, ST_MEMWRITE,
        ST_EXECR, ST_EXECI, ST_ALUWB, ST_BRANCH, ST_JAL, ST_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t     state;
    state_t     state_next;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_rtype;
    logic       f7_zero;
    logic       f7_ok;
    logic [3:0] alu_op;
    logic       alu_legal;
    logic       branch_legal;
    logic       branch_taken;
    logic       unused_instr_bits;

    assign opcode            = Instr[6:0];
    assign funct3            = Instr[14:12];
    assign funct7            = Instr[31:25];
    assign is_rtype          = (opcode == OP_R);
    assign f7_zero           = (funct7 == 7'b0000000);
    assign f7_ok             = f7_zero || (funct7 == 7'b0100000);
    assign unused_instr_bits = ^{Instr[24:15], Instr[11:7]};

    // OP-IMM ignores Instr[30] except on right shifts, so addi with bit 30 set stays an add.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_legal = 1'b1;
        case (funct3)
            3'b000: begin
                alu_op    = (is_rtype && funct7[5]) ? ALU_SUB : ALU_ADD;
                alu_legal = !is_rtype || f7_ok;
            end
            3'b001: begin
                alu_op    = ALU_SLL;
                alu_legal = EXT_ALU && (is_rtype ? f7_zero : f7_ok);
            end
            3'b010: begin
                alu_op    = ALU_SLT;
                alu_legal = !is_rtype || f7_zero;
            end
            3'b011: begin
                alu_op    = ALU_SLTU;
                alu_legal = EXT_ALU && (!is_rtype || f7_zero);
            end
            3'b100: begin
                alu_op    = ALU_XOR;
                alu_legal = EXT_ALU && (!is_rtype || f7_zero);
            end
            3'b101: begin
                alu_op    = funct7[5] ? ALU_SRA : ALU_SRL;
                alu_legal = EXT_ALU && f7_ok;
            end
            3'b110: begin
                alu_op    = ALU_OR;
                alu_legal = !is_rtype || f7_zero;
            end
            default: begin
                alu_op    = ALU_AND;
                alu_legal = !is_rtype || f7_zero;
            end
        endcase
    end

    // Carry means "no borrow" on rs1-rs2, so unsigned less-than is !Carry.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = Zero;
            3'b001:  branch_taken = !Zero;
            3'b100:  branch_taken = Neg ^ Ovf;
            3'b101:  branch_taken = !(Neg ^ Ovf);
            3'b110:  branch_taken = !Carry;
            3'b111:  branch_taken = Carry;
            default: branch_taken = 1'b0;
        endcase
    end

    assign branch_legal = (funct3[2:1] == 2'b00) || (FULL_BRANCH && funct3[2]);

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_next;
    end

    // NOTE: each always_comb assigns a default first so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:    if (MemReady) state_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = ST_MEMADR;
                    OP_R:              state_next = alu_legal ? ST_EXECR : ST_TRAP;
                    OP_I:              state_next = alu_legal ? ST_EXECI : ST_TRAP;
                    OP_BRANCH:         state_next = branch_legal ? ST_BRANCH : ST_TRAP;
                    OP_JAL:            state_next = ST_JAL;
                    default:           state_next = ST_TRAP;
                endcase
            end
            ST_MEMADR:   state_next = (opcode == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (MemReady) state_next = ST_MEMWB;
            ST_MEMWRITE: if (MemReady) state_next = ST_FETCH;
            ST_MEMWB:    state_next = ST_FETCH;
            ST_EXECR:    state_next = ST_ALUWB;
            ST_EXECI:    state_next = ST_ALUWB;
            ST_ALUWB:    state_next = ST_FETCH;
            ST_BRANCH:   state_next = ST_FETCH;
            ST_JAL:      state_next = ST_ALUWB;
            ST_TRAP:     state_next = TRAP_HALT ? ST_TRAP : ST_FETCH;
            default:     state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        Illegal    = 1'b0;
        case (opcode)
            OP_LOAD, OP_I: ImmSrc = 2'b00;
            OP_STORE:      ImmSrc = 2'b01;
            OP_BRANCH:     ImmSrc = 2'b10;
            OP_JAL:        ImmSrc = 2'b11;
            default:       ImmSrc = 2'b00;
        endcase
        case (state)
            ST_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            ST_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            ST_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            ST_MEMREAD:  AdrSrc = 1'b1;
            ST_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            ST_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            ST_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_op;
            end
            ST_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_op;
            end
            ST_ALUWB:    RegWrite = 1'b1;
            ST_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = branch_taken;
            end
            ST_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            ST_TRAP:     Illegal = 1'b1;
            default:     ;
        endcase
        // Reset kills every write in the cycle it is raised, including a pending store.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (full-featured and minimal), each driven
// with directed and random instructions and compared cycle by cycle to a per-instruction script.
module tb_multicycle_controller;
    typedef enum {K_LOAD, K_STORE, K_R, K_I, K_BR, K_JAL, K_ILL} kind_e;
    typedef struct {
        logic [17:0] exp;
        bit          mr;
        bit          rst;
    } cyc_t;

    localparam logic [3:0] A_ADD  = 4'b0000;
    localparam logic [3:0] A_SUB  = 4'b0001;
    localparam logic [3:0] A_AND  = 4'b0010;
    localparam logic [3:0] A_OR   = 4'b0011;
    localparam logic [3:0] A_XOR  = 4'b0100;
    localparam logic [3:0] A_SLT  = 4'b0101;
    localparam logic [3:0] A_SLL  = 4'b0110;
    localparam logic [3:0] A_SRL  = 4'b0111;
    localparam logic [3:0] A_SRA  = 4'b1000;
    localparam logic [3:0] A_SLTU = 4'b1001;

    // Mnemonic tables: add sub and or xor slt sltu sll srl sra
    localparam logic [2:0] R_F3  [10] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd2, 3'd3, 3'd1, 3'd5, 3'd5};
    localparam logic [6:0] R_F7  [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20};
    localparam logic [3:0] R_ALU [10] = '{A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLT, A_SLTU, A_SLL, A_SRL, A_SRA};
    localparam bit         R_BAS [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    // addi slti sltiu xori ori andi slli srli srai
    localparam logic [2:0] I_F3  [9] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5};
    localparam logic [6:0] I_F7  [9] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20};
    localparam logic [3:0] I_ALU [9] = '{A_ADD, A_SLT, A_SLTU, A_XOR, A_OR, A_AND, A_SLL, A_SRL, A_SRA};
    localparam bit         I_BAS [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [2:0] B_F3  [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [2];
    logic [31:0] instr_v [2];
    logic [3:0]  flags_v [2];  // {Zero, Neg, Carry, Ovf}
    logic        mr_v    [2];
    logic [17:0] obs     [2];

    // Instance 0: all features on; instance 1: minimal branch/ALU set, non-halting trap.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       pcw, irw, mw, rw, adr, ill;
        logic [1:0] sa, sb, rs, imm;
        logic [3:0] alu;
        multicycle_controller #(
            .FULL_BRANCH(g == 0), .EXT_ALU(g == 0), .TRAP_HALT(g == 0)
        ) dut (
            .clk(clk), .rst(rst_v[g]), .Instr(instr_v[g]),
            .Zero(flags_v[g][3]), .Neg(flags_v[g][2]), .Carry(flags_v[g][1]), .Ovf(flags_v[g][0]),
            .MemReady(mr_v[g]),
            .PCWrite(pcw), .IRWrite(irw), .MemWrite(mw), .RegWrite(rw), .AdrSrc(adr),
            .ALUSrcA(sa), .ALUSrcB(sb), .ResultSrc(rs), .ImmSrc(imm), .ALUControl(alu),
            .Illegal(ill)
        );
        assign obs[g] = {pcw, irw, mw, rw, adr, sa, sb, rs, imm, alu, ill};
    end

    cyc_t       q[$];
    logic [1:0] cur_imm;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [17:0] mk(input bit pcw, input bit irw, input bit mw, input bit rw,
                                       input bit adr, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] rs, input logic [3:0] alu, input bit ill);
        return {pcw, irw, mw, rw, adr, sa, sb, rs, cur_imm, alu, ill};
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic push(input logic [17:0] e, input bit mr, input bit r);
        q.push_back('{exp: e, mr: mr, rst: r});
    endtask

    // Expected cycle-by-cycle script of one instruction, from FETCH up to the cycle before the next FETCH.
    task automatic plan(input int d, input kind_e k, input bit legal, input logic [3:0] alu,
                        input bit taken, input int fst, input int mst);
        for (int i = 0; i < fst; i++) push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, A_ADD, 1'b0), 1'b0, 1'b0);
        push(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, A_ADD, 1'b0), 1'b1, 1'b0);
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, A_ADD, 1'b0), rb(), 1'b0);
        if (!legal) begin
            for (int i = 0; i < ((d == 0) ? 10 : 1); i++)
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 1'b1), rb(), 1'b0);
            if (d == 0) push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0), rb(), 1'b1);
            return;
        end
        case (k)
            K_LOAD, K_STORE: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, A_ADD, 1'b0), rb(), 1'b0);
                for (int i = 0; i <= mst; i++)
                    push(mk(1'b0, 1'b0, k == K_STORE, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0), i == mst, 1'b0);
                if (k == K_LOAD)
                    push(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, A_ADD, 1'b0), rb(), 1'b0);
            end
            K_R, K_I: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, (k == K_I) ? 2'b01 : 2'b00, 2'b00, alu, 1'b0), rb(), 1'b0);
                push(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0), rb(), 1'b0);
            end
            K_BR: push(mk(taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, A_SUB, 1'b0), rb(), 1'b0);
            K_JAL: begin
                push(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, A_ADD, 1'b0), rb(), 1'b0);
                push(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0), rb(), 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic execute(input int d, input string name, input logic [31:0] ins, input logic [3:0] fl);
        cyc_t e;
        int   c = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            if (c == 0) begin
                instr_v[d] = ins;
                flags_v[d] = fl;
            end
            rst_v[d] = e.rst;
            mr_v[d]  = e.mr;
            #1;
            check($sformatf("%s dut%0d cyc%0d instr=%h", name, d, c, ins), 32'(obs[d]), 32'(e.exp));
            c++;
        end
        // Park the instance in FETCH so it idles while the other one runs.
        @(negedge clk);
        mr_v[d]  = 1'b0;
        rst_v[d] = 1'b0;
    endtask

    // Signed/unsigned compare outcomes expressed through the subtraction flags of rs1-rs2.
    function automatic bit br_taken(input logic [2:0] f3, input logic [3:0] fl);
        bit z = fl[3], lt_s = fl[2] ^ fl[0], lt_u = !fl[1];
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return lt_s;
            3'd5:    return !lt_s;
            3'd6:    return lt_u;
            default: return !lt_u;
        endcase
    endfunction

    task automatic random_instr(input int d);
        int          cat = int'($urandom_range(0, 11));
        int          i;
        logic [31:0] ins;
        kind_e       k = K_ILL;
        bit          legal = 1'b0;
        bit          taken = 1'b0;
        logic [3:0]  alu = A_ADD;
        logic [3:0]  fl = 4'($urandom);
        logic [4:0]  rd = 5'($urandom), rs1 = 5'($urandom), rs2 = 5'($urandom);
        logic [11:0] imm12 = 12'($urandom);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  op;
        bit          full = (d == 0);
        cur_imm = 2'b00;
        case (cat)
            0: begin
                ins = {imm12, rs1, 3'b010, rd, 7'b0000011}; k = K_LOAD; legal = 1'b1;
            end
            1: begin
                ins = {imm12[11:5], rs2, rs1, 3'b010, imm12[4:0], 7'b0100011}; k = K_STORE; legal = 1'b1;
                cur_imm = 2'b01;
            end
            2, 3: begin
                i = int'($urandom_range(0, 9));
                ins = {R_F7[i], rs2, rs1, R_F3[i], rd, 7'b0110011};
                k = K_R; alu = R_ALU[i]; legal = R_BAS[i] || full;
            end
            4, 5: begin
                i = int'($urandom_range(0, 8));
                f7 = (i >= 6) ? I_F7[i] : imm12[11:5];
                ins = {f7, imm12[4:0], rs1, I_F3[i], rd, 7'b0010011};
                k = K_I; alu = I_ALU[i]; legal = I_BAS[i] || full;
            end
            6, 7: begin
                f3 = B_F3[$urandom_range(0, 5)];
                ins = {imm12[11:5], rs2, rs1, f3, imm12[4:0], 7'b1100011};
                k = K_BR; legal = full || (f3 < 3'd2); taken = br_taken(f3, fl);
                cur_imm = 2'b10;
            end
            8: begin
                ins = {20'($urandom), rd, 7'b1101111}; k = K_JAL; legal = 1'b1; cur_imm = 2'b11;
            end
            9: begin
                do op = 7'($urandom);
                while (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111});
                ins = {25'($urandom), op};
            end
            10: begin
                ins = {imm12[11:5], rs2, rs1, 2'b01, 1'($urandom), imm12[4:0], 7'b1100011};
                cur_imm = 2'b10;
            end
            default: begin
                do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
                if (rb()) ins = {f7, rs2, rs1, 3'($urandom), rd, 7'b0110011};
                else      ins = {f7, rs2, rs1, rb() ? 3'b001 : 3'b101, rd, 7'b0010011};
            end
        endcase
        plan(d, k, legal, alu, taken, rb() ? 0 : int'($urandom_range(1, 3)), rb() ? 0 : int'($urandom_range(1, 3)));
        execute(d, $sformatf("rand%0d", cat), ins, fl);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; instr_v[d] = 32'h0; flags_v[d] = 4'h0; mr_v[d] = 1'b1;
        end
        cur_imm = 2'b00;
        // Second reset cycle: FETCH with MemReady high, yet no write enable may assert.
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            check($sformatf("reset_fetch dut%0d", d), 32'(obs[d]),
                  32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, A_ADD, 1'b0)));
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b0; mr_v[d] = 1'b0;
        end

        cur_imm = 2'b00; plan(0, K_LOAD, 1'b1, A_ADD, 1'b0, 0, 0);
        execute(0, "lw", 32'h00412283, 4'h0);
        cur_imm = 2'b01; plan(0, K_STORE, 1'b1, A_ADD, 1'b0, 0, 3);
        execute(0, "sw_wait3", {7'd0, 5'd5, 5'd1, 3'b010, 5'd4, 7'b0100011}, 4'h0);
        cur_imm = 2'b10; plan(0, K_BR, 1'b1, A_ADD, 1'b1, 0, 0);
        execute(0, "blt_taken", 32'h0020C463, 4'b0100);
        cur_imm = 2'b10; plan(0, K_BR, 1'b1, A_ADD, 1'b0, 0, 0);
        execute(0, "blt_not_taken", 32'h0020C463, 4'b0101);
        cur_imm = 2'b10; plan(1, K_BR, 1'b0, A_ADD, 1'b0, 0, 0);
        execute(1, "blt_min", 32'h0020C463, 4'b0100);
        cur_imm = 2'b00; plan(0, K_R, 1'b1, A_SRA, 1'b0, 0, 0);
        execute(0, "sra", 32'h4020D1B3, 4'h0);
        cur_imm = 2'b00; plan(1, K_R, 1'b0, A_SRA, 1'b0, 0, 0);
        execute(1, "sra_min", 32'h4020D1B3, 4'h0);
        cur_imm = 2'b00; plan(0, K_ILL, 1'b0, A_ADD, 1'b0, 0, 0);
        execute(0, "op7f_halt", 32'h0000007F, 4'h0);
        cur_imm = 2'b00; plan(1, K_ILL, 1'b0, A_ADD, 1'b0, 0, 0);
        execute(1, "op7f_pulse", 32'h0000007F, 4'h0);

        // Reset in the third MEMWRITE wait cycle: store enable must drop in that same cycle.
        cur_imm = 2'b01; plan(0, K_STORE, 1'b1, A_ADD, 1'b0, 0, 3);
        void'(q.pop_back());
        void'(q.pop_back());
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0), 1'b0, 1'b1);
        execute(0, "sw_reset", {7'd0, 5'd6, 5'd2, 3'b010, 5'd8, 7'b0100011}, 4'h0);
        cur_imm = 2'b11; plan(0, K_JAL, 1'b1, A_ADD, 1'b0, 1, 0);
        execute(0, "jal_after_reset", 32'h008000EF, 4'h0);

        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 80; n++) random_instr(d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
